hotspot_locator: RTL and testbench



---
 rtl/hotspot_locator.sv | 152 +++++++++++++++
 tb/tb_hotspot_locator.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hotspot_locator.sv
// Hotspot locator: finds the peak cell of one raster-ordered power frame and
// maps it to panel pixel coordinates, with optional IIR smoothing of the position.
module hotspot_locator #(
  parameter int              GRID_W       = 16,
  parameter int              GRID_H       = 8,
  parameter int              DW           = 32,
  parameter int              X_STEP       = 30,
  parameter int              X_OFF        = 15,
  parameter int              Y_STEP       = 34,
  parameter int              Y_OFF        = 17,
  parameter logic [DW-1:0]   THRESH       = 1000,
  parameter int              SMOOTH_SHIFT = 2
) (
  input  logic                clk_pix,
  input  logic                rst_n,
  input  logic                pwr_valid,
  input  logic                pwr_sof,
  input  logic [DW-1:0]       pwr_data,
  output logic signed [31:0]  pix_x,
  output logic signed [31:0]  pix_y,
  output logic                ena,
  output logic                hot_found,
  output logic                frame_err,
  output logic [1:0]          o_state
);

  localparam int CW = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam int RW = (GRID_H > 1) ? $clog2(GRID_H) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SCAN   = 2'd1;
  localparam logic [1:0] S_MAP    = 2'd2;
  localparam logic [1:0] S_SMOOTH = 2'd3;

  logic [1:0]          r_state;
  logic [CW-1:0]       r_col;
  logic [RW-1:0]       r_row;
  logic [CW-1:0]       r_max_col;
  logic [RW-1:0]       r_max_row;
  logic [DW-1:0]       r_max;
  logic signed [15:0]  r_tx;
  logic signed [15:0]  r_ty;
  logic signed [31:0]  r_pix_x;
  logic signed [31:0]  r_pix_y;
  logic                r_ena;
  logic                r_hot;
  logic                r_err;
  logic                r_first;

  logic                w_sof;
  logic                w_load;
  logic                w_last_col;
  logic                w_last_row;
  logic [15:0]         w_tx;
  logic [15:0]         w_ty;
  logic signed [16:0]  w_dx;
  logic signed [16:0]  w_dy;
  logic signed [16:0]  w_sx;
  logic signed [16:0]  w_sy;

  // A sof beat in IDLE or SCAN (re)starts a frame with itself as index 0.
  assign w_sof      = pwr_valid & pwr_sof;
  assign w_load     = w_sof && (r_state == S_IDLE || r_state == S_SCAN);
  assign w_last_col = (r_col == CW'(GRID_W - 1));
  assign w_last_row = (r_row == RW'(GRID_H - 1));

  assign w_tx = 16'(32'(r_max_col) * X_STEP + X_OFF);
  assign w_ty = 16'(32'(r_max_row) * Y_STEP + Y_OFF);

  // 17-bit signed difference; >>> floors toward negative infinity.
  assign w_dx = {r_tx[15], r_tx} - r_pix_x[16:0];
  assign w_dy = {r_ty[15], r_ty} - r_pix_y[16:0];
  assign w_sx = w_dx >>> SMOOTH_SHIFT;
  assign w_sy = w_dy >>> SMOOTH_SHIFT;

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_col     <= '0;
      r_row     <= '0;
      r_max_col <= '0;
      r_max_row <= '0;
      r_max     <= '0;
      r_tx      <= '0;
      r_ty      <= '0;
      r_pix_x   <= '0;
      r_pix_y   <= '0;
      r_ena     <= 1'b0;
      r_hot     <= 1'b0;
      r_err     <= 1'b0;
      r_first   <= 1'b1;
    end else begin
      r_ena <= 1'b0;
      r_err <= w_sof && (r_state != S_IDLE);
      if (w_load) begin
        r_max     <= pwr_data;
        r_max_col <= '0;
        r_max_row <= '0;
        r_col     <= CW'(1);
        r_row     <= '0;
        r_state   <= S_SCAN;
      end else if (r_state == S_SCAN && pwr_valid) begin
        // Strict greater-than keeps the earliest raster index on ties.
        if (pwr_data > r_max) begin
          r_max     <= pwr_data;
          r_max_col <= r_col;
          r_max_row <= r_row;
        end
        if (w_last_col) begin
          r_col <= '0;
          r_row <= r_row + RW'(1);
          if (w_last_row) r_state <= S_MAP;
        end else begin
          r_col <= r_col + CW'(1);
        end
      end

      if (r_state == S_MAP) begin
        if (r_max < THRESH) begin
          r_hot   <= 1'b0;
          r_state <= S_IDLE;
        end else begin
          r_tx    <= w_tx;
          r_ty    <= w_ty;
          r_state <= S_SMOOTH;
        end
      end

      if (r_state == S_SMOOTH) begin
        if (r_first || SMOOTH_SHIFT == 0) begin
          r_pix_x <= {{16{r_tx[15]}}, r_tx};
          r_pix_y <= {{16{r_ty[15]}}, r_ty};
          r_first <= 1'b0;
        end else begin
          r_pix_x <= r_pix_x + {{15{w_sx[16]}}, w_sx};
          r_pix_y <= r_pix_y + {{15{w_sy[16]}}, w_sy};
        end
        r_ena   <= 1'b1;
        r_hot   <= 1'b1;
        r_state <= S_IDLE;
      end
    end
  end

  assign pix_x     = r_pix_x;
  assign pix_y     = r_pix_y;
  assign ena       = r_ena;
  assign hot_found = r_hot;
  assign frame_err = r_err;
  assign o_state   = r_state;

endmodule

// File: tb/tb_hotspot_locator.sv
// Scoreboard bench for hotspot_locator: stimulus pushes expected coordinates,
// a negedge monitor pops and compares on every ena strobe.
module tb_hotspot_locator;

  localparam int GW    = 16;
  localparam int NCELL = 128;
  localparam int SHIFT = 2;

  logic               clk_pix = 1'b0;
  logic               rst_n = 1'b0;
  logic               pwr_valid = 1'b0;
  logic               pwr_sof = 1'b0;
  logic [31:0]        pwr_data = '0;
  logic signed [31:0] pix_x;
  logic signed [31:0] pix_y;
  logic               ena;
  logic               hot_found;
  logic               frame_err;
  logic [1:0]         o_state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int err_seen = 0;
  int err_exp = 0;

  // {expected cycle, pix_x, pix_y}
  logic [95:0] exp_q[$];
  logic [31:0] fr[NCELL];

  int m_px = 0;
  int m_py = 0;
  bit m_first = 1'b1;
  bit m_hot = 1'b0;

  hotspot_locator dut (
    .clk_pix   (clk_pix),
    .rst_n     (rst_n),
    .pwr_valid (pwr_valid),
    .pwr_sof   (pwr_sof),
    .pwr_data  (pwr_data),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .ena       (ena),
    .hot_found (hot_found),
    .frame_err (frame_err),
    .o_state   (o_state)
  );

  // clock / cycle counter
  always #5 clk_pix = ~clk_pix;
  always @(posedge clk_pix) cyc <= cyc + 1;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor
  always @(negedge clk_pix) begin
    logic [95:0] e;
    if (frame_err) err_seen++;
    if (ena) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ena", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("ena_cycle", cyc, $signed(e[95:64]));
        check("pix_x", pix_x, $signed(e[63:32]));
        check("pix_y", pix_y, $signed(e[31:0]));
      end
    end
  end

  function automatic int floor_div(input int d, input int div);
    int q;
    q = d / div;
    if (d < 0 && q * div != d) q = q - 1;
    return q;
  endfunction

  // reference: argmax with earliest index on ties, then map and smooth
  task automatic model_frame(input int m);
    int best;
    int tx;
    int ty;
    best = 0;
    for (int i = 1; i < NCELL; i++)
      if (fr[i] > fr[best]) best = i;
    if (fr[best] >= 1000) begin
      tx = (best % GW) * 30 + 15;
      ty = (best / GW) * 34 + 17;
      if (m_first) begin
        m_px = tx;
        m_py = ty;
        m_first = 1'b0;
      end else begin
        m_px = m_px + floor_div(tx - m_px, 1 << SHIFT);
        m_py = m_py + floor_div(ty - m_py, 1 << SHIFT);
      end
      exp_q.push_back({32'(m + 3), 32'(m_px), 32'(m_py)});
      m_hot = 1'b1;
    end else begin
      m_hot = 1'b0;
    end
  endtask

  // driver tasks
  task automatic beat(input logic [31:0] d, input logic sof, input int gap_pct,
                      output int m);
    while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
      pwr_valid = 1'b0;
      pwr_sof   = 1'($urandom_range(0, 1));
      pwr_data  = $urandom;
      @(negedge clk_pix);
    end
    pwr_valid = 1'b1;
    pwr_sof   = sof;
    pwr_data  = d;
    m = cyc;
    @(negedge clk_pix);
    pwr_valid = 1'b0;
    pwr_sof   = 1'b0;
  endtask

  task automatic send_partial(input int n);
    int m;
    for (int i = 0; i < n; i++) beat(fr[i], i == 0, 0, m);
  endtask

  task automatic send_frame(input int gap_pct, input bit tail_sof);
    int m;
    for (int i = 0; i < NCELL; i++) beat(fr[i], i == 0, gap_pct, m);
    model_frame(m);
    if (tail_sof) begin
      // lands while the FSM is in MAP: dropped, flagged as an error
      pwr_valid = 1'b1;
      pwr_sof   = 1'b1;
      pwr_data  = 32'hFFFF_FFFF;
      @(negedge clk_pix);
      pwr_valid = 1'b0;
      pwr_sof   = 1'b0;
      err_exp++;
      repeat (3) @(negedge clk_pix);
    end else begin
      repeat (4) @(negedge clk_pix);
    end
    check("ena_count_drained", exp_q.size(), 0);
    check("hot_found", hot_found, m_hot);
    check("pix_x_hold", pix_x, m_px);
    check("pix_y_hold", pix_y, m_py);
  endtask

  task automatic do_reset();
    pwr_valid = 1'b0;
    pwr_sof   = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk_pix);
    check("rst_pix_x", pix_x, 0);
    check("rst_pix_y", pix_y, 0);
    check("rst_ena", ena, 0);
    check("rst_hot_found", hot_found, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_state", o_state, 0);
    exp_q.delete();
    m_first = 1'b1;
    m_px = 0;
    m_py = 0;
    m_hot = 1'b0;
    rst_n = 1'b1;
    @(negedge clk_pix);
  endtask

  task automatic fill(input logic [31:0] v);
    for (int i = 0; i < NCELL; i++) fr[i] = v;
  endtask

  initial begin
    @(negedge clk_pix);
    do_reset();

    fill(10);
    fr[3*GW + 5] = 5000;
    send_frame(0, 1'b0);

    fill(10);
    fr[6*GW + 13] = 6000;
    send_frame(0, 1'b0);

    fill(10);
    fr[0] = 7000;
    send_frame(0, 1'b1);

    do_reset();
    fill(100);
    fr[2]  = 4000;
    fr[40] = 4000;
    send_frame(0, 1'b0);

    fill(999);
    send_frame(0, 1'b0);

    // restart mid-frame: sof reasserted at sample 50
    fill(20);
    fr[17] = 9000;
    send_partial(50);
    err_exp++;
    fill(30);
    fr[9*1 + 4*GW] = 3000;
    send_frame(0, 1'b0);
    check("frame_err_count", err_seen, err_exp);

    fill(10);
    fr[3*GW + 5] = 5000;
    send_frame(30, 1'b0);

    // reset in the middle of a frame
    fill(10);
    fr[100] = 8000;
    send_partial(60);
    do_reset();
    fill(10);
    fr[2*GW + 7] = 2500;
    send_frame(0, 1'b0);

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < NCELL; i++)
        fr[i] = $urandom_range(0, (k % 3 == 0) ? 1100 : 50000);
      send_frame($urandom_range(0, 40), k == 4);
    end

    check("frame_err_total", err_seen, err_exp);
    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
